// File: rtl/apu_resp_reorder.sv
// APU front-end: grants CPU requests with a tag, collects out-of-order completions,
// formats the scalar result and returns results to the CPU strictly in grant order.
module apu_resp_reorder #(
   parameter int VLEN   = 128,
   parameter int XLEN   = 32,
   parameter int DEPTH  = 4,
   parameter int FLAG_W = 5,
   parameter int VL_W   = $clog2(VLEN/8) + 1,
   parameter int TAG_W  = $clog2(DEPTH)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         apu_req,
   output logic                         apu_gnt,
   input  logic                         issue_ready,
   output logic [TAG_W-1:0]             grant_tag,
   input  logic                         cmpl_valid,
   input  logic [TAG_W-1:0]             cmpl_tag,
   input  logic [1:0]                   cmpl_src,
   input  logic [VL_W-1:0]              cmpl_vl,
   input  logic [VLEN-1:0]              cmpl_vs2,
   input  logic [1:0]                   cmpl_vsew,
   input  logic [$clog2(VLEN/8)-1:0]    cmpl_idx,
   input  logic                         cmpl_sext,
   input  logic [FLAG_W-1:0]            cmpl_flags,
   output logic                         apu_rvalid,
   output logic [XLEN-1:0]              apu_result,
   output logic [FLAG_W-1:0]            apu_flags_o,
   output logic [$clog2(DEPTH+1)-1:0]   outstanding,
   output logic                         err_o
);

   localparam int CNT_W = $clog2(DEPTH+1);

   localparam logic [1:0] SRC_NONE = 2'd0;
   localparam logic [1:0] SRC_VL   = 2'd1;
   localparam logic [1:0] SRC_VS2  = 2'd2;

   logic [DEPTH-1:0]  alloc;
   logic [DEPTH-1:0]  done;
   logic [XLEN-1:0]   res_mem  [DEPTH];
   logic [FLAG_W-1:0] flag_mem [DEPTH];
   logic [TAG_W-1:0]  head;
   logic [TAG_W-1:0]  tail;

   logic              accept;
   logic              head_bypass;
   logic              retire;
   logic [XLEN-1:0]   ret_res;
   logic [FLAG_W-1:0] ret_flags;

   int                elem_w;
   int                shamt;
   logic [XLEN-1:0]   low_mask;
   logic [XLEN-1:0]   elem_raw;
   logic              sign_bit;
   logic              illegal;
   logic [XLEN-1:0]   fmt_res;
   logic [FLAG_W-1:0] fmt_flags;

   assign apu_gnt   = apu_req & issue_ready & (outstanding < CNT_W'(DEPTH)) & ~reset;
   assign grant_tag = tail;

   // Element extraction: the sign bit is the top bit of the low mask, which avoids
   // a variable bit-select on the shifted vector.
   always_comb begin
      elem_w    = 8 << cmpl_vsew;
      shamt     = int'(cmpl_idx) << (3 + int'(cmpl_vsew));
      low_mask  = (XLEN'(1) << elem_w) - XLEN'(1);
      elem_raw  = XLEN'(cmpl_vs2 >> shamt) & low_mask;
      sign_bit  = |(elem_raw & (low_mask ^ (low_mask >> 1)));
      illegal   = (cmpl_src == 2'd3) ||
                  ((cmpl_src == SRC_VS2) &&
                   ((cmpl_vsew == 2'd3) || (elem_w > XLEN) || (shamt >= VLEN)));
      fmt_res   = '0;
      fmt_flags = cmpl_flags;
      case (cmpl_src)
         SRC_NONE: fmt_res = '0;
         SRC_VL:   fmt_res = XLEN'(cmpl_vl);
         SRC_VS2:  fmt_res = elem_raw | ((cmpl_sext & sign_bit) ? ~low_mask : '0);
         default:  fmt_res = '0;
      endcase
      if (illegal) begin
         fmt_res   = '0;
         fmt_flags = cmpl_flags | FLAG_W'(1);
      end
   end

   // A completion for the tag being granted this cycle is rejected naturally:
   // its alloc bit only rises on the grant edge.
   always_comb begin
      accept      = cmpl_valid & alloc[cmpl_tag] & ~done[cmpl_tag];
      head_bypass = accept & (cmpl_tag == head);
      retire      = (alloc[head] & done[head]) | head_bypass;
      ret_res     = head_bypass ? fmt_res   : res_mem[head];
      ret_flags   = head_bypass ? fmt_flags : flag_mem[head];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         alloc       <= '0;
         done        <= '0;
         head        <= '0;
         tail        <= '0;
         outstanding <= '0;
         apu_rvalid  <= 1'b0;
         apu_result  <= '0;
         apu_flags_o <= '0;
         err_o       <= 1'b0;
      end else begin
         if (apu_gnt) begin
            alloc[tail] <= 1'b1;
            done[tail]  <= 1'b0;
            tail        <= tail + TAG_W'(1);
         end
         if (accept && !head_bypass) begin
            done[cmpl_tag] <= 1'b1;
         end
         // Grant never targets head while retiring (that would need a full buffer).
         if (retire) begin
            alloc[head] <= 1'b0;
            done[head]  <= 1'b0;
            head        <= head + TAG_W'(1);
            apu_result  <= ret_res;
            apu_flags_o <= ret_flags;
         end
         apu_rvalid <= retire;
         if (cmpl_valid && !accept) begin
            err_o <= 1'b1;
         end
         case ({apu_gnt, retire})
            2'b10:   outstanding <= outstanding + CNT_W'(1);
            2'b01:   outstanding <= outstanding - CNT_W'(1);
            default: outstanding <= outstanding;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (accept && !head_bypass) begin
         res_mem[cmpl_tag]  <= fmt_res;
         flag_mem[cmpl_tag] <= fmt_flags;
      end
   end

endmodule
